// File: rtl/wb_wake_csr_pkg.sv
// wb_wake_csr_pkg
//   Shared constants for the wake-word CSR block.
//   - Register byte offsets inside the 256-byte window.
//   - Bit positions of the CTRL and STATUS fields.
//   - The Wishbone handshake state type.
//   - A helper that packs the STATUS word.
package wb_wake_csr_pkg;

  // Register byte offsets; address bits [1:0] are cleared before comparing.
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_TS     = 8'h0C;
  localparam logic [7:0] OFF_POP    = 8'h10;

  // CTRL fields; both live in byte lane 0.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS fields; OVF lives in byte lane 1.
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_LEVEL_LSB = 2;
  localparam int STAT_LEVEL_MSB = 6;
  localparam int STAT_OVF       = 8;

  // Byte lanes that qualify CTRL writes and the OVF clear.
  localparam int SEL_CTRL = 0;
  localparam int SEL_OVF  = 1;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Assemble the STATUS read word from the individual flags.
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic [4:0] level,
                                              input logic       ovf);
    logic [31:0] w;
    w = 32'h0;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL] = full;
    w[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level;
    w[STAT_OVF] = ovf;
    return w;
  endfunction

endpackage

// File: rtl/wb_wake_csr_fifo.sv
// sync_fifo
//   Single-clock FIFO. A push into a full FIFO is taken only when a pop
//   happens in the same cycle, so a full FIFO can be read and written at once.
//   DEPTH must be a power of two; the pointers wrap naturally.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     push_i, din_i  : write request and data
//     pop_i, dout_o  : read request and head entry (valid while not empty)
//     full_o, empty_o, level_o : occupancy flags and entry count
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == LW'(0));
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, letting a push into a full FIFO land.
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Pointer and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer, level and storage registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/wb_wake_csr.sv
// wb_wake_csr
//   Wishbone slave giving firmware control of the wake-word detector: an
//   enable bit, a count of accepted wake events, a free-running timestamp and
//   a FIFO of event timestamps, plus a level interrupt.
//   Ports:
//     clk_i, rst_n_i       : clock, asynchronous active-low reset
//     wbs_*                : Wishbone slave (1-cycle ack, 1 access per 2 cycles)
//     wake_valid_i         : single-cycle wake-detect pulse
//     enable_o             : registered copy of CTRL.EN
//     irq_o                : registered IRQ_EN & (FIFO not empty | OVF)
module wb_wake_csr
  import wb_wake_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TS_WIDTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wake_valid_i,
  output logic        enable_o,
  output logic        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  bus_state_e          state_q, state_d;
  logic                req_s, acc_s, rd_s, wr_s;
  logic [7:0]          off_s;
  logic                ctrl_wr_s, ovf_clr_s, pop_s, accept_s, ovf_set_s;
  logic                ctrl_en_q, ctrl_en_d, irq_en_q, irq_en_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         count_q, count_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                enable_q, enable_d, irq_q, irq_d;
  logic [31:0]         dat_q, dat_d, rdata_s, status_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0]    fifo_level_s;
  logic [TS_WIDTH-1:0] fifo_dout_s;
  logic                unused_s;

  // Address bits and data bits that no register field uses.
  assign unused_s = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:9], wbs_dat_i[7:2]};

  // Request decode. An access is serviced only from IDLE, which is what
  // spaces held strobes to one ack every second cycle.
  assign req_s = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc_s = (state_q == BUS_IDLE) & req_s;
  assign rd_s  = acc_s & ~wbs_we_i;
  assign wr_s  = acc_s & wbs_we_i;
  assign off_s = {wbs_adr_i[7:2], 2'b00};

  assign ctrl_wr_s = wr_s & (off_s == OFF_CTRL) & wbs_sel_i[SEL_CTRL];
  assign ovf_clr_s = wr_s & (off_s == OFF_STATUS) & wbs_sel_i[SEL_OVF] & wbs_dat_i[STAT_OVF];
  assign pop_s     = rd_s & (off_s == OFF_POP) & ~fifo_empty_s;

  // The registered EN is used, so a CTRL write clearing EN still lets the
  // coincident wake pulse through.
  assign accept_s  = wake_valid_i & ctrl_en_q;
  assign ovf_set_s = accept_s & fifo_full_s & ~pop_s;

  sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .din_i   (ts_q),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  assign status_s = pack_status(fifo_empty_s, fifo_full_s, 5'(fifo_level_s), ovf_q);

  // Handshake state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state: every ack is followed by one idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: begin
        if (req_s) begin
          state_d = BUS_ACK;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // Handshake output: ack is the ACK state itself, so it drops with reset.
  always_comb begin
    wbs_ack_o = 1'b0;
    case (state_q)
      BUS_ACK: wbs_ack_o = 1'b1;
      default: wbs_ack_o = 1'b0;
    endcase
  end

  // Read mux; the POP offset returns 0 rather than stale storage when empty.
  always_comb begin
    rdata_s = 32'h0;
    case (off_s)
      OFF_CTRL: begin
        rdata_s[CTRL_EN]     = ctrl_en_q;
        rdata_s[CTRL_IRQ_EN] = irq_en_q;
      end
      OFF_STATUS: rdata_s = status_s;
      OFF_COUNT:  rdata_s = count_q;
      OFF_TS:     rdata_s = 32'(ts_q);
      OFF_POP: begin
        if (fifo_empty_s) begin
          rdata_s = 32'h0;
        end else begin
          rdata_s = 32'(fifo_dout_s);
        end
      end
      default: rdata_s = 32'h0;
    endcase
  end

  // Register next-state. OVF set takes priority over a coincident W1C.
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    irq_en_d  = irq_en_q;
    if (ctrl_wr_s) begin
      ctrl_en_d = wbs_dat_i[CTRL_EN];
      irq_en_d  = wbs_dat_i[CTRL_IRQ_EN];
    end else begin
      ctrl_en_d = ctrl_en_q;
      irq_en_d  = irq_en_q;
    end
    ovf_d = ovf_set_s | (ovf_q & ~ovf_clr_s);
    if (accept_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    ts_d     = ts_q + TS_WIDTH'(1);
    enable_d = ctrl_en_q;
    irq_d    = irq_en_q & (~fifo_empty_s | ovf_q);
    // Read data is held only for the ack cycle and is 0 otherwise.
    if (rd_s) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'h0;
    end
  end

  // Control, status, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= 32'h0;
      ts_q      <= '0;
      enable_q  <= 1'b0;
      irq_q     <= 1'b0;
      dat_q     <= 32'h0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      ts_q      <= ts_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      dat_q     <= dat_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign enable_o  = enable_q;
  assign irq_o     = irq_q;

endmodule
